// File: rtl/lifo_regfile_mp.sv
// LIFO register file with push, pop, replace-top, a registered top read
// port and N_RD registered random-read ports; sticky overflow/underflow.
module lifo_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int N_RD   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    input  logic                     i_top_re,
    output logic [DATA_W-1:0]        o_top_data,
    output logic [ADDR_W-1:0]        o_top_addr,
    output logic                     o_top_valid,
    input  logic [N_RD-1:0]          i_rd_re,
    input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [N_RD*DATA_W-1:0]   o_rd_data,
    output logic [N_RD-1:0]          o_rd_valid,
    output logic [ADDR_W:0]          o_count,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_err_ovf,
    output logic                     o_err_udf
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [ADDR_W:0]        r_count;
    logic                   r_err_ovf;
    logic                   r_err_udf;
    logic [DATA_W-1:0]      r_top_data;
    logic [ADDR_W-1:0]      r_top_addr;
    logic                   r_top_valid;
    logic [N_RD*DATA_W-1:0] r_rd_data;
    logic [N_RD-1:0]        r_rd_valid;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_inc;
    logic                   w_dec;
    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_wr_idx;
    logic [ADDR_W-1:0]      w_top_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_DEPTH);
    assign w_top_idx = ADDR_W'(r_count - 1'b1);

    // push&pop on an empty stack degenerates to a plain push
    assign w_inc = i_push && (i_pop ? w_empty : !w_full);
    assign w_dec = i_pop && !i_push && !w_empty;

    assign w_wr_en  = !i_rst && !i_clr && i_push && (i_pop || !w_full);
    assign w_wr_idx = (i_pop && !w_empty) ? w_top_idx : ADDR_W'(r_count);

    // Stack depth and sticky error flags
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count   <= '0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_inc) begin
                r_count <= r_count + 1'b1;
            end else if (w_dec) begin
                r_count <= r_count - 1'b1;
            end
            if (i_push && !i_pop && w_full) begin
                r_err_ovf <= 1'b1;
            end
            if (i_pop && !i_push && w_empty) begin
                r_err_udf <= 1'b1;
            end
        end
    end

    // Storage array write (contents are not reset)
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    // Registered top-of-stack read against pre-edge state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_top_valid <= 1'b0;
            r_top_data  <= '0;
            r_top_addr  <= '0;
        end else if (i_top_re && !w_empty) begin
            r_top_valid <= 1'b1;
            r_top_data  <= r_mem[w_top_idx];
            r_top_addr  <= w_top_idx;
        end else begin
            r_top_valid <= 1'b0;
            r_top_data  <= '0;
            r_top_addr  <= '0;
        end
    end

    // Independent registered random-read ports, bounded by current depth
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_RD; i++) begin
            if (i_rst) begin
                r_rd_valid[i]                 <= 1'b0;
                r_rd_data[i*DATA_W +: DATA_W] <= '0;
            end else if (i_rd_re[i] &&
                         ({1'b0, i_rd_addr[i*ADDR_W +: ADDR_W]} < r_count)) begin
                r_rd_valid[i]                 <= 1'b1;
                r_rd_data[i*DATA_W +: DATA_W] <= r_mem[i_rd_addr[i*ADDR_W +: ADDR_W]];
            end else begin
                r_rd_valid[i]                 <= 1'b0;
                r_rd_data[i*DATA_W +: DATA_W] <= '0;
            end
        end
    end

    assign o_count     = r_count;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_err_ovf   = r_err_ovf;
    assign o_err_udf   = r_err_udf;
    assign o_top_data  = r_top_data;
    assign o_top_addr  = r_top_addr;
    assign o_top_valid = r_top_valid;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;

endmodule
